// File: rtl/fidget_memory_fifo_ctrl_if.sv
// Bundle of the FIFO controller's data-path signals: upstream handshake,
// downstream handshake, occupancy, and the dual-port memory ports.
// The slave modport is the controller's view; master is the surrounding
// environment (producer, consumer and the memory instance).
interface fidget_memory_fifo_ctrl_if #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 256
);
  localparam int AW = $clog2(DEPTH);

  // upstream
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  // downstream
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  // occupancy
  logic [AW+1:0]    count;
  // memory ports
  logic             mem_write_enable;
  logic [AW-1:0]    mem_write_addr;
  logic [WIDTH-1:0] mem_write_data;
  logic             mem_read_enable;
  logic [AW-1:0]    mem_read_addr;
  logic [WIDTH-1:0] mem_read_data;

  modport slave (
    input  in_data, in_valid, out_ready, mem_read_data,
    output in_ready, out_data, out_valid, count,
           mem_write_enable, mem_write_addr, mem_write_data,
           mem_read_enable, mem_read_addr
  );

  modport master (
    output in_data, in_valid, out_ready, mem_read_data,
    input  in_ready, out_data, out_valid, count,
           mem_write_enable, mem_write_addr, mem_write_data,
           mem_read_enable, mem_read_addr
  );
endinterface

// File: rtl/fidget_memory_fifo_ctrl.sv
// Synchronous FIFO controller around an external dual-port block RAM with a
// one-cycle registered read. A two-entry output buffer (head + skid) absorbs
// the read latency so the FIFO can pop one word every cycle.
module fidget_memory_fifo_ctrl #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 256
) (
  input logic                       clock,
  input logic                       reset,
  input logic                       flush,
  fidget_memory_fifo_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] RAM_FULL = (AW+1)'(DEPTH);

  // state
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      ram_count_q, ram_count_d;
  logic             rd_pending_q, rd_pending_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [1:0]       buf_count_q, buf_count_d;

  // handshake / issue terms
  logic       in_ready;
  logic       push;
  logic       pop;
  logic       rd_issue;
  logic [2:0] buf_committed;
  logic [1:0] buf_after_pop;

  // Handshakes and read issue. A read is issued only if the buffer will
  // still have a free slot for it once the outstanding read lands and
  // this cycle's pop has left; that alone guarantees no buffer overflow.
  always_comb begin
    in_ready      = (ram_count_q != RAM_FULL) && !reset && !flush;
    push          = bus.in_valid && in_ready;
    pop           = (buf_count_q != 2'd0) && bus.out_ready;
    buf_committed = {1'b0, buf_count_q} + {2'b00, rd_pending_q} - {2'b00, pop};
    rd_issue      = (ram_count_q != '0) && (buf_committed < 3'd2) && !flush && !reset;
    buf_after_pop = buf_count_q - {1'b0, pop};
  end

  // Next-state: pointers, RAM occupancy, read tracking and output buffer.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ram_count_d  = ram_count_q;
    rd_pending_d = rd_issue;
    head_d       = head_q;
    skid_d       = skid_q;
    buf_count_d  = buf_after_pop;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // A word written this cycle only becomes readable next cycle.
    ram_count_d = ram_count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, rd_issue};

    // Popping with both entries full promotes the skid word to head.
    if (pop && (buf_count_q == 2'd2)) begin
      head_d = skid_q;
    end
    // Returning read data fills the first free slot after the pop.
    if (rd_pending_q) begin
      if (buf_after_pop == 2'd0) begin
        head_d = bus.mem_read_data;
      end else begin
        skid_d = bus.mem_read_data;
      end
      buf_count_d = buf_after_pop + 2'd1;
    end
  end

  // State register; flush clears everything, including any in-flight read.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_count_q  <= '0;
      rd_pending_q <= 1'b0;
      head_q       <= '0;
      skid_q       <= '0;
      buf_count_q  <= 2'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_count_q  <= ram_count_d;
      rd_pending_q <= rd_pending_d;
      head_q       <= head_d;
      skid_q       <= skid_d;
      buf_count_q  <= buf_count_d;
    end
  end

  // Output wiring.
  assign bus.in_ready         = in_ready;
  assign bus.out_valid        = (buf_count_q != 2'd0);
  assign bus.out_data         = head_q;
  assign bus.count            = {1'b0, ram_count_q} + {{AW+1{1'b0}}, rd_pending_q}
                              + {{AW{1'b0}}, buf_count_q};
  assign bus.mem_write_enable = push;
  assign bus.mem_write_addr   = wr_ptr_q;
  assign bus.mem_write_data   = bus.in_data;
  assign bus.mem_read_enable  = rd_issue;
  assign bus.mem_read_addr    = rd_ptr_q;

endmodule

// File: tb/tb_fidget_memory_fifo_ctrl.sv
// Testbench for fidget_memory_fifo_ctrl: behavioural memory, a queue-based
// reference model of the FIFO contents, directed and random stimulus.
module tb_fidget_memory_fifo_ctrl;
  localparam int WIDTH = 80;
  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  logic clock = 1'b0;
  logic reset;
  logic flush;

  fidget_memory_fifo_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fidget_memory_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Behavioural dual-port RAM with registered read.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (bus.mem_write_enable) mem[bus.mem_write_addr] <= bus.mem_write_data;
    if (bus.mem_read_enable)  bus.mem_read_data <= mem[bus.mem_read_addr];
  end

  // Reference model: the ordered list of words the FIFO currently holds.
  logic [WIDTH-1:0] model_q [$];

  int n_chk = 0;
  int n_err = 0;

  logic             last_push;
  logic             last_pop;
  logic [WIDTH-1:0] last_pop_data;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  // One clock cycle: sample before the edge, check against the model,
  // then apply the accepted push/pop to the model at the edge.
  task automatic tick();
    logic [WIDTH-1:0] push_data;
    @(negedge clock);
    last_push = bus.in_valid && bus.in_ready;
    last_pop  = bus.out_valid && bus.out_ready && !flush && !reset;
    push_data = bus.in_data;
    if (!reset && !flush) begin
      check_eq("count", 128'(bus.count), 128'(model_q.size()));
      if (model_q.size() < DEPTH) check_eq("in_ready_not_full", 128'(bus.in_ready), 128'(1));
      if (model_q.size() == 0)    check_eq("out_valid_empty", 128'(bus.out_valid), 128'(0));
    end else begin
      check_eq("in_ready_in_clear", 128'(bus.in_ready), 128'(0));
    end
    if (last_pop && model_q.size() != 0) begin
      last_pop_data = model_q.pop_front();
      check_eq("out_data", 128'(bus.out_data), 128'(last_pop_data));
    end
    @(posedge clock);
    if (reset || flush) model_q.delete();
    else if (last_push) model_q.push_back(push_data);
    #1;
  endtask

  task automatic drain(input string tag);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (model_q.size() == 0) break;
      tick();
    end
    check_eq(tag, 128'(model_q.size()), 128'(0));
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    int max_count;
    int pops;
    int accepted;
    int saw_pop;

    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    last_pop_data = '0;

    // Reset, then idle.
    repeat (3) tick();
    check_eq("reset_in_ready_low", 128'(bus.in_ready), 128'(0));
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle_in_ready", 128'(bus.in_ready), 128'(1));
      check_eq("idle_out_valid", 128'(bus.out_valid), 128'(0));
      check_eq("idle_count", 128'(bus.count), 128'(0));
      check_eq("idle_out_data", 128'(bus.out_data), 128'(0));
      check_eq("idle_mem_we", 128'(bus.mem_write_enable), 128'(0));
      check_eq("idle_mem_re", 128'(bus.mem_read_enable), 128'(0));
    end

    // Single word: pushed at E0, visible after E2, popped at E3.
    w = 80'h1234_5678_9ABC_DEF0_1357;
    bus.in_valid = 1'b1; bus.in_data = w; bus.out_ready = 1'b1;
    tick();  // E0
    bus.in_valid = 1'b0;
    check_eq("single_push", 128'(last_push), 128'(1));
    check_eq("single_cnt_e0", 128'(bus.count), 128'(1));
    check_eq("single_ov_e0", 128'(bus.out_valid), 128'(0));
    tick();  // E1
    check_eq("single_cnt_e1", 128'(bus.count), 128'(1));
    check_eq("single_ov_e1", 128'(bus.out_valid), 128'(0));
    tick();  // E2
    check_eq("single_cnt_e2", 128'(bus.count), 128'(1));
    check_eq("single_ov_e2", 128'(bus.out_valid), 128'(1));
    check_eq("single_data_e2", 128'(bus.out_data), 128'(w));
    tick();  // E3
    check_eq("single_pop_e3", 128'(last_pop), 128'(1));
    check_eq("single_cnt_e3", 128'(bus.count), 128'(0));
    check_eq("single_ov_e3", 128'(bus.out_valid), 128'(0));
    $display("single word %0h done", w);

    // Streaming 0..999 with the consumer always ready.
    max_count = 0; pops = 0;
    for (int i = 0; i < 1000; i++) begin
      bus.in_valid = 1'b1; bus.in_data = WIDTH'(i); bus.out_ready = 1'b1;
      tick();
      if (last_pop) pops++;
      if (int'(bus.count) > max_count) max_count = int'(bus.count);
    end
    check_eq("stream_max_count_le3", 128'(max_count <= 3), 128'(1));
    check_eq("stream_pops", 128'(pops), 128'(997));
    drain("stream_drain");
    $display("streaming: 1000 words, max count %0d, pops during push %0d", max_count, pops);

    // Fill with backpressure, then drain.
    accepted = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = 1'b1; bus.in_data = rand_word();
      tick();
      if (!last_push) break;
      accepted++;
    end
    check_eq("fill_accepted", 128'(accepted), 128'(DEPTH + 2));
    check_eq("fill_count", 128'(bus.count), 128'(DEPTH + 2));
    bus.out_ready = 1'b1;
    check_eq("full_in_ready_with_pop", 128'(bus.in_ready), 128'(0));
    tick();
    check_eq("full_no_push", 128'(last_push), 128'(0));
    drain("fill_drain");
    $display("fill: accepted %0d words, drained", accepted);

    // Random stall.
    for (int i = 0; i < 20000; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = rand_word();
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain("random_drain");
    $display("random: 20000 cycles done");

    // Flush with 100 words stored and a read in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = 1'b1; bus.in_data = WIDTH'(5000 + i);
      tick();
    end
    check_eq("flush_pre_count", 128'(bus.count), 128'(100));
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();  // pop + new read issue
    flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = rand_word();
    tick();
    flush = 1'b0;
    check_eq("flush_push_blocked", 128'(last_push), 128'(0));
    check_eq("flush_count", 128'(bus.count), 128'(0));
    check_eq("flush_out_valid", 128'(bus.out_valid), 128'(0));
    bus.in_valid = 1'b1; bus.in_data = WIDTH'('hA5);
    tick();
    bus.in_valid = 1'b0;
    saw_pop = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_pop) begin saw_pop = 1; break; end
    end
    check_eq("flush_pop_seen", 128'(saw_pop), 128'(1));
    check_eq("flush_first_word", 128'(last_pop_data), 128'('hA5));
    repeat (5) tick();
    check_eq("flush_after_empty", 128'(bus.out_valid), 128'(0));
    $display("flush: first word after flush %0h", last_pop_data);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fidget_memory_fifo_ctrl.md
Name: fidget_memory_fifo_ctrl

Overview:
- Sequences one dual-port 80-bit block-RAM memory instance as a synchronous FIFO.
- Upstream side: valid/ready handshake. Downstream side: valid/ready handshake.
- Drives the memory's write and read ports, and hides the memory's 1-cycle registered read latency behind a 2-entry output buffer, so sustained throughput is 1 word/cycle.
- Sits between producer and consumer stages that need deep 80-bit buffering.

Parameters:
- WIDTH, 80, data width; must equal the memory data width.
- DEPTH, 256, memory words; power of 2, at least 4.
- AW, $clog2(DEPTH), address width (derived; do not override).

Ports:
- clock  in  1  sole clock; also drives the memory write and read clocks.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous clear of all contents.
- in_data  in  WIDTH  write word.
- in_valid  in  1  producer has a word.
- in_ready  out  1  FIFO can accept a word.
- out_data  out  WIDTH  head word.
- out_valid  out  1  head word valid.
- out_ready  in  1  consumer takes the head word.
- count  out  AW+2  total words held: RAM + in-flight read + output buffer.
- mem_write_enable  out  1  memory write enable.
- mem_write_addr  out  AW  memory write address.
- mem_write_data  out  WIDTH  memory write data.
- mem_read_enable  out  1  memory read enable.
- mem_read_addr  out  AW  memory read address.
- mem_read_data  in  WIDTH  memory read data, valid 1 cycle after a read is issued.

Behaviour:
- State:
  - wr_ptr, rd_ptr (AW bits, wrap DEPTH-1 -> 0).
  - ram_count (0..DEPTH).
  - rd_pending (1 bit).
  - 2-entry output buffer: head register, skid register, buf_count 0..2.
- Reset or flush: all state cleared to 0. Outputs after that edge: in_ready=1 (0 while reset/flush is asserted), out_valid=0, out_data=0, count=0, mem_write_enable=0, mem_read_enable=0.
- Flush drops any in-flight read; data returning the next cycle is discarded. Flush has priority over push and pop in the same cycle.
- Push:
  - Occurs when in_valid && in_ready.
  - in_ready = (ram_count != DEPTH) && !reset && !flush, combinational.
  - On push: mem_write_enable=1, mem_write_addr=wr_ptr, mem_write_data=in_data (combinational). wr_ptr increments at the edge.
- Pop:
  - Occurs when out_valid && out_ready.
  - out_valid = (buf_count != 0). out_data = head register.
  - On pop: the skid register moves to head if it is occupied.
- Read issue (combinational):
  - Condition: mem_read_enable = (ram_count != 0) && (buf_count + rd_pending - pop) < 2 && !flush.
  - mem_read_addr = rd_ptr. rd_ptr increments and ram_count decrements at the edge.
  - rd_pending takes the value of mem_read_enable.
- Read return: when rd_pending=1, mem_read_data is written at the edge into head if head is free after this cycle's pop, else into skid. The buffer never overflows, by construction of the issue condition.
- No read-during-write hazard: a word written this cycle is not counted in ram_count until the next cycle, so it cannot be read in the same cycle.
- ram_count next = ram_count + push - read_issue. A simultaneous push and read leaves it unchanged.
- count = ram_count + rd_pending + buf_count. Maximum is DEPTH+2; count never exceeds it.
- Latency:
  - A word pushed into an empty FIFO at edge E0 is read-issued in the cycle after E0.
  - It is visible with out_valid=1 after edge E2, so out_valid rises 2 cycles after the accepting edge.
- Throughput: with continuous push and out_ready=1, one pop per cycle in steady state.
- Full: ram_count==DEPTH forces in_ready=0 even if out_ready=1 in the same cycle. A pop frees RAM space only through a subsequent read issue.
- Empty: out_valid=0 and out_data holds its last value (0 after reset). No read is issued.
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
- Reset then idle: after reset, in_ready=1, out_valid=0, count=0, mem_write_enable=0, mem_read_enable=0 for 10 cycles.
- Single word: push 80'h1234_5678_9ABC_DEF0_1357 at edge E0, out_ready=1 -> out_valid=1 after E2 with the same data; popped at E3; count sequence 1,1,1,0.
- Streaming: push 0..999 every cycle with out_ready=1 -> outputs 0..999 in order, one per cycle after the 2-cycle fill latency; count never exceeds 3.
- Fill and backpressure: out_ready=0, push until in_ready=0 -> exactly DEPTH+2=258 words accepted, count=258. Then out_ready=1 -> 258 words drain in order with no loss or duplication.
- Random stall: random in_valid and out_ready (50%) for 20000 cycles against a scoreboard -> order preserved; no push while in_ready=0; no pop while out_valid=0.
- Flush mid-operation: with 100 words stored and a read in flight, assert flush for 1 cycle -> next cycle count=0, out_valid=0. A subsequent push of 80'hA5 emerges first, and stale data never appears.
